wb_bus_arbiter: RTL and testbench
=================================

Name: wb_bus_arbiter

Overview:
Two-master, one-slave Wishbone classic arbiter. It shares a single memory port between the CPU instruction bus (ibus) and data bus (dbus). It sits between the CPU top level and the SoC memory/peripheral interconnect. Grant is held for the whole bus cycle (cyc), so a multi-beat or stalled transfer is never split between masters.

Parameters:
ROUND_ROBIN, 1, 1 = alternate grant on simultaneous requests; 0 = fixed priority, dbus wins.
TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with the optional feature; legal range 1..65535.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ibus__adr, dbus__adr  in  30  master word address [31:2]
ibus__dat_w, dbus__dat_w  in  32  master write data
ibus__sel, dbus__sel  in  4  master byte selects
ibus__cyc, ibus__stb, ibus__we, dbus__cyc, dbus__stb, dbus__we  in  1 each  master cycle / strobe / write enable
ibus__dat_r, dbus__dat_r  out  32  read data returned to the master
ibus__ack, ibus__err, dbus__ack, dbus__err  out  1 each  master termination signals
mem__adr  out  30  slave word address
mem__dat_w  out  32  slave write data
mem__sel  out  4  slave byte selects
mem__cyc, mem__stb, mem__we  out  1 each  slave cycle / strobe / write enable
mem__dat_r  in  32  slave read data
mem__ack, mem__err  in  1 each  slave termination signals
grant  out  2  one-hot state: 2'b01 = ibus granted, 2'b10 = dbus granted, 2'b00 = idle

Behaviour:
- State machine: IDLE, GNT_I, GNT_D. Registered state; all outputs are combinational from the state.
- Reset (rst=1 at a clk edge): state = IDLE, last_grant = dbus, watchdog counter = 0. Consequently grant = 0, mem__cyc = mem__stb = 0 and all master ack/err = 0 from the cycle after reset.
- IDLE: mem__cyc = mem__stb = 0; mem__adr, mem__dat_w, mem__sel and mem__we are driven from dbus (don't-care).
- IDLE arbitration:
  - Only ibus__cyc high -> GNT_I. Only dbus__cyc high -> GNT_D.
  - Both high, ROUND_ROBIN=1 -> grant the master that is not last_grant.
  - Both high, ROUND_ROBIN=0 -> GNT_D.
  - last_grant updates on each grant.
- Latency: one cycle from master cyc rising to mem__cyc rising. The master simply sees one extra wait state; Wishbone semantics need no bypass path.
- GNT_x:
  - mem__adr/dat_w/sel/we/cyc/stb = the granted master's signals.
  - Granted master's ack = mem__ack, err = mem__err, dat_r = mem__dat_r.
  - Non-granted master's ack = err = 0; its dat_r = mem__dat_r (harmless).
- GNT_x exit: sampled at clk when the granted master's cyc = 0.
  - If the other master's cyc = 1 -> go directly to the other GNT (no idle bubble).
  - Else -> IDLE.
  - The same round-robin/priority rule applies at this hand-over.
- Grant hold: a master keeping cyc high across several stb/ack beats keeps the grant indefinitely. Fairness is per cycle, not per beat.
- mem__ack/mem__err arriving in IDLE (protocol violation by the slave): ignored, not routed to either master.
- Simultaneous ack and err from the slave: passed through unchanged. The arbiter does not resolve them.
- Reset mid-transfer: the bus is dropped immediately (next cycle mem__cyc = 0) and any outstanding slave ack is discarded.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter increments each cycle in which state is GNT_x and mem__stb=1 and mem__ack=0 and mem__err=0.
  - The counter clears on ack, on err, on leaving GNT_x, and on reset.
  - When the counter equals TIMEOUT_CYCLES, for that one cycle: the granted master's err = 1, mem__cyc = mem__stb = 0, and the counter clears.
  - The master is expected to drop cyc; the normal exit rules then apply.
- Not defined: no counter exists, no err is ever synthesised, and slaves may stall forever.

Test Plan:
- Reset, then ibus__cyc=stb=1, adr=30'h100, ack after 2 cycles -> mem__cyc rises 1 cycle after ibus__cyc; grant=01; ibus__ack=1 exactly when mem__ack=1; dbus__ack stays 0.
- ibus and dbus both raise cyc in the same cycle, ROUND_ROBIN=1, last_grant=dbus after reset -> ibus granted first. After ibus drops cyc, grant switches to 10 on the next cycle with no IDLE cycle. A repeat contention then grants ibus again.
- ROUND_ROBIN=0, same contention repeated 3 times -> dbus granted every time; ibus is serviced only when dbus__cyc=0.
- dbus holds cyc for 4 beats (dat_w 32'hDEADBEEF, sel 4'b0011, we=1) while ibus requests -> grant stays 10 for all 4 acks; mem__dat_w=32'hDEADBEEF and mem__sel=4'b0011 throughout.
- Assert rst during GNT_D with mem__ack pending -> next cycle grant=00, mem__cyc=0, dbus__ack=0.
- WB_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, slave never acks an ibus strobe -> ibus__err=1 for exactly one cycle, 8 cycles after mem__stb rose, with mem__cyc=0 in that cycle. Without the macro, the same stimulus keeps mem__cyc=1 indefinitely.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: two-master Wishbone classic arbiter sharing one slave port between ibus and dbus.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that errors a stalled granted master after TIMEOUT_CYCLES.
module wb_bus_arbiter #(
    parameter bit          ROUND_ROBIN    = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] ibus__adr,
    input  logic [31:0] ibus__dat_w,
    input  logic [3:0]  ibus__sel,
    input  logic        ibus__cyc,
    input  logic        ibus__stb,
    input  logic        ibus__we,
    output logic [31:0] ibus__dat_r,
    output logic        ibus__ack,
    output logic        ibus__err,
    input  logic [29:0] dbus__adr,
    input  logic [31:0] dbus__dat_w,
    input  logic [3:0]  dbus__sel,
    input  logic        dbus__cyc,
    input  logic        dbus__stb,
    input  logic        dbus__we,
    output logic [31:0] dbus__dat_r,
    output logic        dbus__ack,
    output logic        dbus__err,
    output logic [29:0] mem__adr,
    output logic [31:0] mem__dat_w,
    output logic [3:0]  mem__sel,
    output logic        mem__cyc,
    output logic        mem__stb,
    output logic        mem__we,
    input  logic [31:0] mem__dat_r,
    input  logic        mem__ack,
    input  logic        mem__err,
    output logic [1:0]  grant
);
    typedef enum logic [1:0] {IDLE = 2'b00, GNT_I = 2'b01, GNT_D = 2'b10} state_t;
    state_t state, pick, nxt;
    logic   last_d, gi, gd, stb_g, to;

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..65535");
    end

    assign gi    = state == GNT_I;
    assign gd    = state == GNT_D;
    assign stb_g = (gi && ibus__stb) || (gd && dbus__stb);
    // Contention: round robin favours the master not granted last, fixed priority favours dbus.
    assign pick  = (ibus__cyc && !(dbus__cyc && (!ROUND_ROBIN || !last_d))) ? GNT_I :
                   dbus__cyc ? GNT_D : IDLE;
    assign nxt   = ((gi && ibus__cyc) || (gd && dbus__cyc)) ? state : pick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            last_d <= 1'b1;
        end else begin
            state <= nxt;
            if (nxt != state && nxt != IDLE) last_d <= nxt == GNT_D;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] cnt;
    assign to = cnt == 16'(TIMEOUT_CYCLES);
    always_ff @(posedge clk) begin
        if (rst || nxt != state || to || mem__ack || mem__err) cnt <= '0;
        else if (stb_g) cnt <= cnt + 16'd1;
    end
`else
    assign to = 1'b0;
`endif

    assign grant       = state;
    assign mem__adr    = gi ? ibus__adr : dbus__adr;
    assign mem__dat_w  = gi ? ibus__dat_w : dbus__dat_w;
    assign mem__sel    = gi ? ibus__sel : dbus__sel;
    assign mem__we     = gi ? ibus__we : dbus__we;
    assign mem__cyc    = ((gi && ibus__cyc) || (gd && dbus__cyc)) && !to;
    assign mem__stb    = stb_g && !to;
    assign ibus__ack   = gi && mem__ack;
    assign ibus__err   = gi && (mem__err || to);
    assign dbus__ack   = gd && mem__ack;
    assign dbus__err   = gd && (mem__err || to);
    assign ibus__dat_r = mem__dat_r;
    assign dbus__dat_r = mem__dat_r;
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb_wb_bus_arbiter: random two-master traffic into a round-robin and a fixed-priority arbiter,
// checked each cycle against a bus-ownership model plus a per-beat scoreboard on the round-robin one.
module tb_wb_bus_arbiter;
    localparam int TOUT = 8;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    typedef struct {
        logic [29:0] adr;
        logic [31:0] dat_w;
        logic [3:0]  sel;
        logic        we;
    } beat_t;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic        m_cyc[2], m_stb[2], m_we[2];
    logic [29:0] m_adr[2];
    logic [31:0] m_dat_w[2];
    logic [3:0]  m_sel[2];
    logic [31:0] mem_dat_r;
    logic        mem_ack, mem_err;

    logic [31:0] i_dat_r[2], d_dat_r[2], o_dat_w[2];
    logic        i_ack[2], i_err[2], d_ack[2], d_err[2], o_cyc[2], o_stb[2], o_we[2];
    logic [29:0] o_adr[2];
    logic [3:0]  o_sel[2];
    logic [1:0]  grant[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        wb_bus_arbiter #(.ROUND_ROBIN(g == 0), .TIMEOUT_CYCLES(TOUT)) u_dut (
            .clk(clk), .rst(rst),
            .ibus__adr(m_adr[0]), .ibus__dat_w(m_dat_w[0]), .ibus__sel(m_sel[0]),
            .ibus__cyc(m_cyc[0]), .ibus__stb(m_stb[0]), .ibus__we(m_we[0]),
            .ibus__dat_r(i_dat_r[g]), .ibus__ack(i_ack[g]), .ibus__err(i_err[g]),
            .dbus__adr(m_adr[1]), .dbus__dat_w(m_dat_w[1]), .dbus__sel(m_sel[1]),
            .dbus__cyc(m_cyc[1]), .dbus__stb(m_stb[1]), .dbus__we(m_we[1]),
            .dbus__dat_r(d_dat_r[g]), .dbus__ack(d_ack[g]), .dbus__err(d_err[g]),
            .mem__adr(o_adr[g]), .mem__dat_w(o_dat_w[g]), .mem__sel(o_sel[g]),
            .mem__cyc(o_cyc[g]), .mem__stb(o_stb[g]), .mem__we(o_we[g]),
            .mem__dat_r(mem_dat_r), .mem__ack(mem_ack), .mem__err(mem_err),
            .grant(grant[g])
        );
    end

    int    checks = 0, errors = 0;
    beat_t q0[$], q1[$];
    int    left[2], gap[2];
    logic  ack_l[2], err_l[2];
    bit    stall, force_ack, quiet, arm, started, tox;
    int    own[2] = '{-1, -1};
    int    last[2] = '{1, 1};
    int    wd[2] = '{0, 0};
    int    nxt;

    function automatic logic [31:0] rdata(input logic [29:0] a);
        return {a, 2'b00} ^ 32'hA5A5_0F0F;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d at %0t: got %h expected %h", name, d, $time, act, exp);
        end
    endtask

    task automatic new_beat(input int m);
        beat_t b;
        m_adr[m]   = 30'($urandom);
        m_dat_w[m] = $urandom;
        m_sel[m]   = 4'($urandom);
        m_we[m]    = 1'($urandom);
        b.adr = m_adr[m]; b.dat_w = m_dat_w[m]; b.sel = m_sel[m]; b.we = m_we[m];
        if (m == 0) q0.push_back(b);
        else q1.push_back(b);
    endtask

    task automatic drive(input int m);
        if (m_cyc[m] && (ack_l[m] || err_l[m])) begin
            left[m]--;
            if (left[m] == 0 || err_l[m]) begin
                m_cyc[m] = 1'b0;
                m_stb[m] = 1'b0;
                gap[m]   = int'($urandom_range(3));
            end else new_beat(m);
        end else if (!m_cyc[m]) begin
            if (gap[m] > 0) gap[m]--;
            else if (!quiet && $urandom_range(2) == 0) begin
                m_cyc[m] = 1'b1;
                m_stb[m] = 1'b1;
                left[m]  = int'($urandom_range(4, 1));
                new_beat(m);
            end
        end
    endtask

    // One bus cycle: masters update, then the slave answers, then terminations are latched.
    task automatic step(input bit r);
        int s;
        @(negedge clk);
        #1;
        force_ack = 1'b0;
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                m_cyc[m] = 1'b0; m_stb[m] = 1'b0; gap[m] = 0;
            end
            q0.delete();
            q1.delete();
        end else for (int m = 0; m < 2; m++) drive(m);
        if (arm && grant[0] == 2'b10 && m_cyc[1]) begin
            rst = 1'b1; force_ack = 1'b1; arm = 1'b0;
        end else rst = r;
        #1;
        if (stall) begin
            mem_ack = 1'b0; mem_err = 1'b0;
        end else if (o_cyc[0] && o_stb[0]) begin
            s = int'($urandom_range(15));
            mem_ack = force_ack || s < 7 || s == 15;
            mem_err = !force_ack && s >= 13;
        end else begin
            mem_ack = grant[0] == 2'b00 && $urandom_range(3) == 0;
            mem_err = 1'b0;
        end
        mem_dat_r = rdata(o_adr[0]);
        #2;
        ack_l[0] = i_ack[0]; err_l[0] = i_err[0];
        ack_l[1] = d_ack[0]; err_l[1] = d_err[0];
    endtask

    task automatic score(input int m, input logic ack);
        beat_t b;
        checks++;
        if ((m == 0 ? q0.size() : q1.size()) == 0) begin
            errors++;
            $display("FAIL sb_empty m%0d at %0t: got termination, expected no beat outstanding", m, $time);
            return;
        end
        if (m == 0) b = q0.pop_front();
        else b = q1.pop_front();
        chk("sb_adr", m, 32'(o_adr[0]), 32'(b.adr));
        chk("sb_dat_w", m, o_dat_w[0], b.dat_w);
        chk("sb_sel", m, 32'(o_sel[0]), 32'(b.sel));
        chk("sb_we", m, 32'(o_we[0]), 32'(b.we));
        if (ack) chk("sb_dat_r", m, m == 0 ? i_dat_r[0] : d_dat_r[0], rdata(b.adr));
    endtask

    // Monitor: samples just before each rising edge, then advances the ownership model.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            for (int d = 0; d < 2; d++) begin
                tox = TO_EN && own[d] >= 0 && wd[d] == TOUT;
                if (started) begin
                    chk("grant", d, 32'(grant[d]), own[d] < 0 ? 0 : own[d] == 0 ? 1 : 2);
                    chk("mem_cyc", d, 32'(o_cyc[d]), 32'(own[d] >= 0 && m_cyc[own[d]] && !tox));
                    chk("mem_stb", d, 32'(o_stb[d]), 32'(own[d] >= 0 && m_stb[own[d]] && !tox));
                    if (own[d] >= 0) begin
                        chk("mem_adr", d, 32'(o_adr[d]), 32'(m_adr[own[d]]));
                        chk("mem_dat_w", d, o_dat_w[d], m_dat_w[own[d]]);
                        chk("mem_sel", d, 32'(o_sel[d]), 32'(m_sel[own[d]]));
                        chk("mem_we", d, 32'(o_we[d]), 32'(m_we[own[d]]));
                    end
                    chk("ibus_ack", d, 32'(i_ack[d]), 32'(own[d] == 0 && mem_ack));
                    chk("ibus_err", d, 32'(i_err[d]), 32'(own[d] == 0 && (mem_err || tox)));
                    chk("dbus_ack", d, 32'(d_ack[d]), 32'(own[d] == 1 && mem_ack));
                    chk("dbus_err", d, 32'(d_err[d]), 32'(own[d] == 1 && (mem_err || tox)));
                    chk("ibus_dat_r", d, i_dat_r[d], mem_dat_r);
                    chk("dbus_dat_r", d, d_dat_r[d], mem_dat_r);
                end
                if (rst) begin
                    own[d] = -1; last[d] = 1; wd[d] = 0;
                end else begin
                    nxt = own[d];
                    if (own[d] < 0 || !m_cyc[own[d]])
                        nxt = (m_cyc[0] && m_cyc[1]) ? ((d == 0 && last[d] == 1) ? 0 : 1) :
                              m_cyc[0] ? 0 : m_cyc[1] ? 1 : -1;
                    if (nxt != own[d] || tox || mem_ack || mem_err) wd[d] = 0;
                    else if (own[d] >= 0 && m_stb[own[d]]) wd[d]++;
                    if (nxt >= 0 && nxt != own[d]) last[d] = nxt;
                    own[d] = nxt;
                end
            end
            if (started && !rst) begin
                if (i_ack[0] || i_err[0]) score(0, i_ack[0]);
                if (d_ack[0] || d_err[0]) score(1, d_ack[0]);
            end
            if (rst) started = 1'b1;
        end
    end

    initial begin
        for (int m = 0; m < 2; m++) begin
            m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
            m_adr[m] = '0; m_dat_w[m] = '0; m_sel[m] = '0;
            left[m] = 0; gap[m] = 0; ack_l[m] = 1'b0; err_l[m] = 1'b0;
        end
        mem_ack = 1'b0; mem_err = 1'b0; mem_dat_r = '0;
        repeat (3) step(1'b1);
        repeat (3000) step(1'b0);
        // Slave stops answering: the held grant must stall (or time out when the watchdog exists).
        stall = 1'b1;
        repeat (40) step(1'b0);
        stall = 1'b0;
        // Reset lands while dbus owns the bus and the slave is acking.
        arm = 1'b1;
        for (int i = 0; i < 500 && arm; i++) step(1'b0);
        checks++;
        if (arm) begin
            errors++;
            $display("FAIL rst_in_gnt_d: got no dbus grant within 500 cycles, expected one");
            arm = 1'b0;
        end
        repeat (1000) step(1'b0);
        quiet = 1'b1;
        repeat (60) step(1'b0);
        chk("drain_ibus", 0, q0.size(), 0);
        chk("drain_dbus", 0, q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
